seq_div: RTL
============

// Module: seq_div
// PURPOSE
//   Sequential restoring (shift-subtract) unsigned divider; the inverse of the shift-add multiplier.
//   Computes quot = a_in / b_in and rem = a_in % b_in, one quotient bit per clock.
//   Uses the same start/finish handshake as the multiplier, so the UART datapath control can
//   sequence both blocks identically.
// PARAMETERS
//   N     8    operand width; quot and rem are N bits each
// PORTS
//   clk      in   1   system clock, all state on rising edge
//   reset    in   1   asynchronous, active-low reset (0 = reset asserted)
//   start    in   1   level request; held high for the whole operation
//   a_in     in   N   dividend, sampled on the launch edge only
//   b_in     in   N   divisor, sampled on the launch edge only
//   quot     out  N   quotient, registered, updated only on completion
//   rem      out  N   remainder, registered, updated only on completion
//   busy     out  1   high while iterating
//   finish   out  1   high in DONE; held until start deasserts
//   dbz      out  1   divide-by-zero flag (only exists with DIV_BYZERO_EN)
// BEHAVIOUR
//   Reset (reset=0, any time, asynchronous): state=IDLE.
//     quot=0, rem=0, busy=0, finish=0, dbz=0. The internal shift registers and counter are cleared.
//   FSM: IDLE -> BUSY -> DONE -> IDLE.
//   IDLE: when start=1 at a clock edge, latch the operands:
//     - dividend into shift reg q
//     - divisor into d
//     - partial remainder r (N+1 bits) = 0
//     - counter = N
//     Then go to BUSY with busy=1.
//   BUSY, one iteration per edge:
//     - r = {r[N-1:0], q[N-1]}; q = q << 1
//     - if r >= {1'b0, d}: r = r - d and q[0] = 1
//     - counter decrements
//     - after the iteration with counter==1: quot=q, rem=r[N-1:0], busy=0, finish=1, go to DONE
//   Latency: launch edge k -> finish=1 visible after edge k+N (N=8: 8 cycles after launch).
//   DONE: finish=1 and outputs hold while start=1.
//     When start=0 at an edge: finish=0 and go to IDLE. Outputs keep their last result.
//   start=1 on the edge that leaves DONE is ignored. A new operation requires start low for at least one edge.
//   Abort: start=0 at an edge while in BUSY -> IDLE, busy=0, finish stays 0.
//     quot/rem keep the previous completed result; the partial result is discarded.
//   Operand changes on a_in/b_in after the launch edge have no effect.
//   Divisor 0 without the macro: the algorithm runs all N iterations. Result is quot=all ones, rem=a_in (natural restoring result).
//   Arithmetic is unsigned only. r is N+1 bits so the compare/subtract never overflows. No wrap-around on quot.
// CONFIGURATION
//   DIV_BYZERO_EN defined:
//     - adds the dbz output
//     - b_in==0 at launch: IDLE -> DONE in one edge, no BUSY
//     - quot={N{1'b1}}, rem=a_in, dbz=1, finish=1 after the launch edge
//     - dbz clears when leaving DONE and at reset
//     - nonzero divisors behave exactly as without the macro, with dbz=0
//   DIV_BYZERO_EN undefined: the dbz port is absent; divide-by-zero takes N cycles as described in BEHAVIOUR.
// TESTING
//   1. N=8, a=100, b=7, start held -> finish after 8 cycles, quot=14, rem=2, busy high for exactly those cycles.
//   2. a=255,b=1 -> quot=255,rem=0; a=5,b=9 -> quot=0,rem=5; a=0,b=3 -> quot=0,rem=0.
//   3. a=200,b=0:
//      - without macro: finish after 8 cycles, quot=255, rem=200
//      - with DIV_BYZERO_EN: finish and dbz=1 one edge after launch, same quot/rem
//   4. Complete 100/7, restart with 50/5, drop start 3 cycles into BUSY -> returns IDLE.
//      finish never asserts; quot=14, rem=2 retained.
//   5. Assert reset=0 mid-BUSY between clock edges -> all outputs 0 immediately, without waiting for clk.
//      After release, 9/4 completes with quot=2, rem=1.
//   6. Hold start high after DONE for 5 cycles -> finish stays 1, outputs stable.
//      Then start=0 -> finish=0 next edge, and no new operation launches without a low cycle.

Source files
------------

// File: rtl/seq_div.sv
// Sequential restoring unsigned divider: one quotient bit per clock, start/finish handshake.
// Optional macro DIV_BYZERO_EN adds the dbz output and a one-edge divide-by-zero shortcut.
module seq_div #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [N-1:0] a_in,
   input  logic [N-1:0] b_in,
   output logic [N-1:0] quot,
   output logic [N-1:0] rem,
   output logic         busy,
   output logic         finish
`ifdef DIV_BYZERO_EN
   ,
   output logic         dbz
`endif
);

   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t         state_q, state_d;
   logic [N-1:0]   q, d;
   // The N+1-bit partial remainder only exists inside the step; after the
   // subtract it is always below d, so its top bit is never stored.
   logic [N-1:0]   r;
   logic [CW-1:0]  cnt;
   logic           launch, step, complete;
   logic [2*N-1:0] step_res;
`ifdef DIV_BYZERO_EN
   logic           zero_div;
`endif

   function automatic logic [2*N-1:0] div_step(input logic [N-1:0] r_cur,
                                               input logic [N-1:0] q_cur,
                                               input logic [N-1:0] d_cur);
      logic [N:0]   r_sh;
      logic [N-1:0] q_sh;
      r_sh = {r_cur, q_cur[N-1]};
      q_sh = {q_cur[N-2:0], 1'b0};
      if (r_sh >= {1'b0, d_cur}) begin
         r_sh    = r_sh - {1'b0, d_cur};
         q_sh[0] = 1'b1;
      end
      return {r_sh[N-1:0], q_sh};
   endfunction

   assign step_res = div_step(r, q, d);
   assign busy     = (state_q == BUSY);
   assign finish   = (state_q == DONE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      launch   = 1'b0;
      step     = 1'b0;
      complete = 1'b0;
`ifdef DIV_BYZERO_EN
      zero_div = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
`ifdef DIV_BYZERO_EN
               if (b_in == '0) begin
                  state_d  = DONE;
                  zero_div = 1'b1;
               end else
`endif
               begin
                  state_d = BUSY;
                  launch  = 1'b1;
               end
            end
         end
         BUSY: begin
            // Dropping start mid-run aborts; the partial result is discarded.
            if (!start) begin
               state_d = IDLE;
            end else begin
               step = 1'b1;
               if (cnt == CW'(1)) begin
                  state_d  = DONE;
                  complete = 1'b1;
               end
            end
         end
         DONE: begin
            if (!start) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q    <= '0;
         d    <= '0;
         r    <= '0;
         cnt  <= '0;
         quot <= '0;
         rem  <= '0;
      end else begin
         if (launch) begin
            q   <= a_in;
            d   <= b_in;
            r   <= '0;
            cnt <= CW'(N);
         end else if (step) begin
            r   <= step_res[2*N-1:N];
            q   <= step_res[N-1:0];
            cnt <= cnt - CW'(1);
         end
         if (complete) begin
            quot <= step_res[N-1:0];
            rem  <= step_res[2*N-1:N];
         end
`ifdef DIV_BYZERO_EN
         if (zero_div) begin
            quot <= '1;
            rem  <= a_in;
         end
`endif
      end
   end

`ifdef DIV_BYZERO_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                        dbz <= 1'b0;
      else if (zero_div)                 dbz <= 1'b1;
      else if (state_q == DONE && !start) dbz <= 1'b0;
   end
`endif

endmodule
